// File: rtl/gcm_decrypt_ctrl.sv
// gcm_decrypt_ctrl: AES-GCM decrypt-and-verify sequencer driving external AES and GHASH cores
module gcm_decrypt_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [95:0]      iv,
   input  logic [CNT_W-1:0] ad_nblk,
   input  logic [CNT_W-1:0] ct_nblk,
   input  logic [127:0]     tag_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             aes_req,
   output logic [127:0]     aes_block,
   input  logic             aes_ack,
   input  logic [127:0]     aes_result,
   output logic             gh_req,
   output logic [127:0]     gh_x,
   input  logic             gh_ack,
   input  logic [127:0]     gh_y,
   output logic             busy,
   output logic             done,
   output logic             auth_ok
);
   typedef enum logic [3:0] {IDLE, J0, AD_WAIT, AD_MUL, CT_WAIT, CT_PROC, CT_OUT, LEN, TAG} state_t;
   state_t           state;
   logic [95:0]      iv_r;
   logic [CNT_W-1:0] ad_n, ct_n, ad_cnt, ct_cnt;
   logic [127:0]     tag_r, y, ek_j0, ct_reg, ks;
   logic [31:0]      ctr32;
   logic             aes_got, gh_got;
   logic             aes_hit, gh_hit, aes_fin, gh_fin;
   logic [127:0]     len_blk, ks_now;

   // Acks only count while the matching request is outstanding; a block finishes once both cores answered
   assign aes_hit = aes_req & aes_ack;
   assign gh_hit  = gh_req & gh_ack;
   assign aes_fin = aes_got | aes_hit;
   assign gh_fin  = gh_got | gh_hit;
   assign ks_now  = aes_hit ? aes_result : ks;
   assign len_blk = {64'(ad_n) << 7, 64'(ct_n) << 7};

   // Sequencer: J0 encryption, GHASH over AD, CTR decrypt with parallel GHASH over CT, length block, tag check
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         iv_r      <= '0;
         ad_n      <= '0;
         ct_n      <= '0;
         ad_cnt    <= '0;
         ct_cnt    <= '0;
         tag_r     <= '0;
         y         <= '0;
         ek_j0     <= '0;
         ct_reg    <= '0;
         ks        <= '0;
         ctr32     <= '0;
         aes_got   <= 1'b0;
         gh_got    <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         aes_req   <= 1'b0;
         aes_block <= '0;
         gh_req    <= 1'b0;
         gh_x      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         auth_ok   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               iv_r      <= iv;
               ad_n      <= ad_nblk;
               ct_n      <= ct_nblk;
               ad_cnt    <= ad_nblk;
               ct_cnt    <= ct_nblk;
               tag_r     <= tag_in;
               y         <= '0;
               ek_j0     <= '0;
               ctr32     <= 32'd2;
               auth_ok   <= 1'b0;
               busy      <= 1'b1;
               aes_req   <= 1'b1;
               aes_block <= {iv, 32'h00000001};
               state     <= J0;
            end
            J0: if (aes_hit) begin
               ek_j0   <= aes_result;
               aes_req <= 1'b0;
               if (ad_n != '0) begin
                  in_ready <= 1'b1;
                  state    <= AD_WAIT;
               end else if (ct_n != '0) begin
                  in_ready <= 1'b1;
                  state    <= CT_WAIT;
               end else
                  state <= LEN;
            end
            AD_WAIT: if (in_valid) begin
               in_ready <= 1'b0;
               gh_req   <= 1'b1;
               gh_x     <= y ^ in_data;
               state    <= AD_MUL;
            end
            AD_MUL: if (gh_hit) begin
               gh_req <= 1'b0;
               y      <= gh_y;
               ad_cnt <= ad_cnt - CNT_W'(1);
               if (ad_cnt != CNT_W'(1)) begin
                  in_ready <= 1'b1;
                  state    <= AD_WAIT;
               end else if (ct_n != '0) begin
                  in_ready <= 1'b1;
                  state    <= CT_WAIT;
               end else
                  state <= LEN;
            end
            CT_WAIT: if (in_valid) begin
               in_ready  <= 1'b0;
               ct_reg    <= in_data;
               aes_req   <= 1'b1;
               aes_block <= {iv_r, ctr32};
               gh_req    <= 1'b1;
               gh_x      <= y ^ in_data;
               aes_got   <= 1'b0;
               gh_got    <= 1'b0;
               state     <= CT_PROC;
            end
            CT_PROC: begin
               if (aes_hit) begin
                  aes_req <= 1'b0;
                  aes_got <= 1'b1;
                  ks      <= aes_result;
               end
               if (gh_hit) begin
                  gh_req <= 1'b0;
                  gh_got <= 1'b1;
                  y      <= gh_y;
               end
               if (aes_fin && gh_fin) begin
                  out_data  <= ct_reg ^ ks_now;
                  out_valid <= 1'b1;
                  ctr32     <= ctr32 + 32'd1;
                  state     <= CT_OUT;
               end
            end
            CT_OUT: if (out_ready) begin
               out_valid <= 1'b0;
               ct_cnt    <= ct_cnt - CNT_W'(1);
               if (ct_cnt == CNT_W'(1))
                  state <= LEN;
               else begin
                  in_ready <= 1'b1;
                  state    <= CT_WAIT;
               end
            end
            LEN: if (!gh_req) begin
               gh_req <= 1'b1;
               gh_x   <= y ^ len_blk;
            end else if (gh_ack) begin
               gh_req <= 1'b0;
               y      <= gh_y;
               state  <= TAG;
            end
            TAG: begin
               auth_ok <= ~|(y ^ ek_j0 ^ tag_r);
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
